// File: rtl/ipm_fifo_rd_stream.sv
// ipm_fifo_rd_stream: drains a fixed-latency FIFO read port into a valid/ready stream
// through a small prefetch buffer so the issue logic never depends on data_out_ready.
module ipm_fifo_rd_stream #(
    parameter int W = 8,
    parameter int RD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         fifo_rd_empty,
    output logic         fifo_rd_en,
    input  logic [W-1:0] fifo_rd_data,
    output logic [W-1:0] data_out,
    output logic         data_out_valid,
    input  logic         data_out_ready,
    output logic [2:0]   buf_level
);
    localparam int DEPTH = RD_LAT + 2;
    localparam int PW = $clog2(DEPTH);

    logic [RD_LAT-1:0] lat_q, lat_d;
    logic [W-1:0]      buf_q [DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [2:0]        level_q, level_d, inflight;
    logic              capture, fifo_read;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + 3'(lat_q[i]);
    end

    // Reserve a buffer slot for every read still in flight before issuing another.
    assign fifo_rd_en     = ~fifo_rd_empty & (({1'b0, inflight} + {1'b0, level_q}) < 4'(DEPTH));
    assign capture        = lat_q[RD_LAT-1];
    assign data_out_valid = level_q != '0;
    assign fifo_read      = data_out_valid & data_out_ready;
    assign data_out       = buf_q[rptr_q];
    assign buf_level      = level_q;

    always_comb begin
        lat_d   = RD_LAT'({lat_q, fifo_rd_en});
        wptr_d  = capture ? inc(wptr_q) : wptr_q;
        rptr_d  = fifo_read ? inc(rptr_q) : rptr_q;
        level_d = level_q + 3'(capture) - 3'(fifo_read);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
        end else begin
            lat_q   <= lat_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            if (capture) buf_q[wptr_q] <= fifo_rd_data;
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        ({1'b0, inflight} + {1'b0, level_q}) <= 4'(DEPTH));

endmodule

// File: tb/tb_ipm_fifo_rd_stream.sv
// tb_ipm_fifo_rd_stream: RD_LAT=1 and RD_LAT=2 adapters side by side, each fed by a
// queue-based FIFO model, with a scoreboard monitor checking order, stability and occupancy.
module tb_ipm_fifo_rd_stream;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ready = 1'b0, wr_en = 1'b0, force_empty = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic [1:0] rd_en, empty, valid;
    logic [1:0][W-1:0] rd_data, dout;
    logic [1:0][2:0] lvl;
    logic [W-1:0] pipe [2];
    logic [W-1:0] fq [2][$];
    logic [W-1:0] exp_q [2][$];
    int issued [2];
    int popped [2];
    logic hold [2];
    logic [W-1:0] hdata [2];
    int written = 0, total = 0, bad = 0, chk_kind = 0, chk_req = 0, chk_ack = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : l
        ipm_fifo_rd_stream #(.W(W), .RD_LAT(g + 1)) u_dut (
            .clk(clk), .rst(rst), .fifo_rd_empty(empty[g]), .fifo_rd_en(rd_en[g]),
            .fifo_rd_data(rd_data[g]), .data_out(dout[g]), .data_out_valid(valid[g]),
            .data_out_ready(ready), .buf_level(lvl[g]));
    end

    // Upstream FIFO: registered empty flag, read data RD_LAT cycles after the strobe.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < 2; g++) begin
                empty[g] <= 1'b1;
                rd_data[g] <= '0;
                pipe[g] <= '0;
                issued[g] <= 0;
                fq[g].delete();
                exp_q[g].delete();
            end
        end else begin
            for (int g = 0; g < 2; g++) begin
                empty[g] <= force_empty | (fq[g].size() + int'(wr_en) - int'(rd_en[g] && fq[g].size() != 0) == 0);
                if (rd_en[g]) issued[g] <= issued[g] + 1;
                if (rd_en[g] && fq[g].size() != 0) begin
                    if (g == 0) rd_data[g] <= fq[g].pop_front();
                    else pipe[g] <= fq[g].pop_front();
                end
                if (g == 1) rd_data[g] <= pipe[g];
                if (wr_en) begin
                    fq[g].push_back(wr_data);
                    exp_q[g].push_back(wr_data);
                end
            end
        end
    end

    task automatic chk(input string name, input int g, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s lat%0d: got %0h expected %0h", name, g + 1, act, req);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rst) begin
            hold = '{1'b0, 1'b0};
            popped = '{0, 0};
            chk_ack = chk_req;
        end else begin
            for (int g = 0; g < 2; g++) begin
                int dep;
                int outs;
                dep = g + 3;
                outs = issued[g] - popped[g];
                if (chk_req != chk_ack) begin
                    if (chk_kind == 1) begin
                        chk("rst_valid", g, valid[g], 0);
                        chk("rst_level", g, lvl[g], 0);
                        chk("rst_rd_en", g, rd_en[g], 0);
                        chk("rst_data", g, dout[g], 0);
                    end else if (chk_kind == 2) begin
                        chk("bp_level", g, lvl[g], dep);
                        chk("bp_rd_en", g, rd_en[g], 0);
                        chk("bp_reads", g, outs, dep);
                        chk("bp_valid", g, valid[g], 1);
                        chk("bp_head", g, dout[g], exp_q[g].size() != 0 ? exp_q[g][0] : -1);
                    end else if (chk_kind == 3) begin
                        chk("idle_level", g, lvl[g], 0);
                        chk("idle_valid", g, valid[g], 0);
                        chk("idle_rd_en", g, rd_en[g], 0);
                        chk("idle_pending", g, exp_q[g].size(), 0);
                        chk("idle_reads", g, issued[g], written);
                        chk("idle_pops", g, popped[g], written);
                    end else begin
                        chk("stream_no_bubble", g, valid[g], 1);
                    end
                end
                chk("rd_en_while_empty", g, rd_en[g] & empty[g], 0);
                chk("occupancy_le_depth", g, int'(outs + int'(rd_en[g]) <= dep), 1);
                if (hold[g]) begin
                    chk("hold_valid", g, valid[g], 1);
                    chk("hold_data", g, dout[g], hdata[g]);
                end
                if (valid[g] && ready) begin
                    if (exp_q[g].size() == 0) chk("extra_word", g, 1, 0);
                    else chk("data", g, dout[g], exp_q[g].pop_front());
                    popped[g]++;
                end
                hold[g] = valid[g] & ~ready;
                hdata[g] = dout[g];
            end
            chk_ack = chk_req;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int k);
        chk_kind = k;
        chk_req++;
        tick();
    endtask

    task automatic push(input logic [W-1:0] d);
        wr_en = 1'b1;
        wr_data = d;
        written++;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) tick();
        rst = 1'b0;
        req(1);
        ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(W'(i));
        repeat (12) tick();
        req(3);
        // fill the buffer, then stream with ready held high
        ready = 1'b0;
        for (int i = 0; i < 16; i++) push(W'(8'h10 + i));
        repeat (6) tick();
        ready = 1'b1;
        repeat (16) req(4);
        repeat (10) tick();
        req(3);
        ready = 1'b0;
        for (int i = 0; i < 10; i++) push(W'($urandom));
        repeat (10) tick();
        req(2);
        ready = 1'b1;
        repeat (20) tick();
        req(3);
        // ready toggling against a flapping empty flag
        n = 0;
        for (int i = 0; i < 90; i++) begin
            ready = i[0];
            force_empty = ((i / 3) % 2) == 1;
            wr_en = n < 20 && $urandom_range(0, 1) == 1;
            wr_data = W'($urandom);
            if (wr_en) begin
                written++;
                n++;
            end
            tick();
        end
        wr_en = 1'b0;
        force_empty = 1'b0;
        ready = 1'b1;
        repeat (40) tick();
        req(3);
        for (int i = 0; i < 70; i++) begin
            ready = 1'($urandom_range(0, 1));
            wr_en = i < 13;
            wr_data = W'($urandom);
            if (wr_en) written++;
            tick();
        end
        wr_en = 1'b0;
        ready = 1'b1;
        repeat (20) tick();
        req(3);
        // reset with reads in flight and words buffered
        ready = 1'b0;
        for (int i = 0; i < 4; i++) push(W'($urandom));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        written = 0;
        req(1);
        ready = 1'b1;
        push(8'hA5);
        push(8'h5A);
        repeat (12) tick();
        req(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
